// File: rtl/tt_ranword.sv
// Random-word generator: synchronised entropy bit, Galois-LFSR whitening, word assembly,
// valid/ready hand-out and repetition-count health test. Define TT_RANWORD_VN_EN for von Neumann de-biasing.
module tt_ranword #(
    parameter int                WORD_W    = 4,
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1,
    parameter int                REP_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ent_in,
    input  logic              start,
    input  logic              ready_i,
    input  logic              clr_fail,
    output logic [WORD_W-1:0] word_o,
    output logic              valid_o,
    output logic              busy_o,
    output logic              fail_o
);

    localparam int CNT_W = $clog2(WORD_W + 1);
    localparam int REP_W = $clog2(REP_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, COLLECT, HOLD, FAIL} state_t;

    state_t            state, state_nxt;
    logic              ent_p0, s_p1, s_prev;
    logic [LFSR_W-1:0] lfsr;
    logic [REP_W-1:0]  rep, rep_nxt;
    logic [WORD_W-1:0] shreg, word_q;
    logic [CNT_W-1:0]  cnt;
    logic              b, take, acc_bit, last, trip;

    function automatic logic [REP_W-1:0] rep_sat_inc(input logic [REP_W-1:0] v);
        if (v >= REP_W'(REP_LIMIT))
            return REP_W'(REP_LIMIT);
        else
            return v + REP_W'(1);
    endfunction

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_TAPS : '0);
    endfunction

    assign b = s_p1 ^ lfsr[0];

`ifdef TT_RANWORD_VN_EN
    logic vn_phase, vn_b0;

    // Second bit of a pair decides: unequal pair yields its first bit, equal pair is dropped.
    assign take    = (state == COLLECT) && vn_phase && (vn_b0 != b);
    assign acc_bit = vn_b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vn_phase <= 1'b0;
            vn_b0    <= 1'b0;
        end else if (state == IDLE) begin
            vn_phase <= 1'b0;
        end else if (state == COLLECT) begin
            vn_phase <= ~vn_phase;
            if (!vn_phase)
                vn_b0 <= b;
        end
    end
`else
    assign take    = (state == COLLECT);
    assign acc_bit = b;
`endif

    assign last = take && (cnt == CNT_W'(WORD_W - 1));

    always_comb begin
        rep_nxt = rep;
        if (clr_fail)
            rep_nxt = REP_W'(1);
        else if (state == FAIL)
            rep_nxt = rep;
        else if (s_p1 != s_prev)
            rep_nxt = REP_W'(1);
        else
            rep_nxt = rep_sat_inc(rep);
    end

    // clr_fail outranks a trip detected on the same edge.
    assign trip = (state != FAIL) && !clr_fail && (rep_nxt == REP_W'(REP_LIMIT));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)    state_nxt = COLLECT;
            COLLECT: if (last)     state_nxt = HOLD;
            HOLD:    if (ready_i)  state_nxt = IDLE;
            FAIL:    if (clr_fail) state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
        if (trip)
            state_nxt = FAIL;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_p0 <= 1'b0;
            s_p1   <= 1'b0;
            s_prev <= 1'b0;
            lfsr   <= LFSR_SEED;
            rep    <= REP_W'(1);
            shreg  <= '0;
            word_q <= '0;
            cnt    <= '0;
        end else begin
            ent_p0 <= ent_in;
            s_p1   <= ent_p0;
            s_prev <= s_p1;
            lfsr   <= lfsr_step(lfsr);
            rep    <= rep_nxt;
            if (state == IDLE) begin
                cnt <= '0;
            end else if (take) begin
                shreg <= {shreg[WORD_W-2:0], acc_bit};
                cnt   <= cnt + CNT_W'(1);
            end
            if (trip)
                word_q <= '0;
            else if (last)
                word_q <= {shreg[WORD_W-2:0], acc_bit};
        end
    end

    assign word_o  = word_q;
    assign valid_o = (state == HOLD);
    assign busy_o  = (state == COLLECT);
    assign fail_o  = (state == FAIL);

endmodule
